// File: rtl/octree_pkg.sv
// octree_pkg: shared SRAM geometry and reader FSM state encoding.
package octree_pkg;
  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 64;
  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DRAIN, RD_DONE} rd_state_e;
endpackage

// File: rtl/octree_stream_fifo2.sv
// octree_stream_fifo2: two-entry skid FIFO with registered valid; push and pop may coincide when full.
module octree_stream_fifo2 #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   occ_o
);
  logic [W-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [1:0]   cnt_q, cnt_d, cnt_p;
  logic         valid_q;
  always_comb begin
    cnt_p = cnt_q - {1'b0, pop_i};
    s0_d  = pop_i ? s1_q : s0_q;
    s1_d  = s1_q;
    if (push_i && cnt_p == 2'd0) s0_d = data_i;
    if (push_i && cnt_p == 2'd1) s1_d = data_i;
    cnt_d = cnt_p + {1'b0, push_i};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q    <= '0;
      s1_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      cnt_q   <= cnt_d;
      valid_q <= cnt_d != 2'd0;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = s0_q;
  assign occ_o   = cnt_q;
endmodule

// File: rtl/octree_sram_stream_reader.sv
// octree_sram_stream_reader: bursts len words out of the 1-cycle SRAM into a valid/ready stream.
module octree_sram_stream_reader
  import octree_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int DATA_WIDTH = SRAM_DATA_W,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);
  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, issued_q, issued_d, emitted_q, emitted_d;
  logic                  inflight_q, last_q, pop, req;
  logic [1:0]            occ;
  assign pop = m_valid_o & m_ready_i;
  // Issue only if the word returning next cycle is guaranteed a free slot.
  assign req = (state_q == RD_RUN) && (issued_q != len_q) &&
               (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    issued_d  = issued_q;
    emitted_d = pop ? emitted_q + LEN_WIDTH'(1) : emitted_q;
    case (state_q)
      RD_IDLE: begin
        if (start_i && len_i != '0) begin
          addr_d    = base_addr_i;
          len_d     = len_i;
          issued_d  = '0;
          emitted_d = '0;
          state_d   = RD_RUN;
        end else if (start_i) begin
          state_d = RD_DONE;
        end
      end
      RD_RUN: begin
        if (req) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          issued_d = issued_q + LEN_WIDTH'(1);
        end
        if (issued_d == len_q) state_d = RD_DRAIN;
      end
      RD_DRAIN: if (pop && emitted_q == len_q - LEN_WIDTH'(1)) state_d = RD_DONE;
      default: state_d = RD_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      emitted_q  <= '0;
      inflight_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      emitted_q  <= emitted_d;
      inflight_q <= req;
      last_q     <= req && (issued_q == len_q - LEN_WIDTH'(1));
    end
  end
  octree_stream_fifo2 #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .data_i  ({last_q, sram_rdata_i}),
    .pop_i   (pop),
    .valid_o (m_valid_o),
    .data_o  ({m_last_o, m_data_o}),
    .occ_o   (occ)
  );
  assign busy_o      = (state_q == RD_RUN) || (state_q == RD_DRAIN);
  assign done_o      = state_q == RD_DONE;
  assign sram_req_o  = req;
  assign sram_we_o   = 1'b0;
  assign sram_addr_o = addr_q;
endmodule

// File: tb/tb_octree_sram_stream_reader.sv
// tb_octree_sram_stream_reader: random bursts against a queue-based scoreboard of expected beats and addresses.
module tb_octree_sram_stream_reader;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int LW = 11;
  typedef logic [DW:0] w_t;
  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  logic clk = 0, rst_n = 0, start_i = 0, m_ready_i = 1;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic busy_o, done_o, sram_req_o, sram_we_o, m_valid_o, m_last_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_rdata_i, m_data_o;
  logic [DW-1:0] mem [1024];
  beat_t exp_q[$], held_b, act, b;
  logic [AW-1:0] adr_q[$];
  int beat_cyc[$];
  int tests = 0, fails = 0, cyc = 0, beats = 0, dones = 0, start_cyc = 0, out_n = 0, rmode = 0, ph = 0;
  logic infl_b = 0, busy_m = 0, done_exp = 0, held = 0, pop, nd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (sram_req_o) sram_rdata_i <= mem[sram_addr_o];

  octree_sram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_rdata_i(sram_rdata_i), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o)
  );

  task automatic chk(input string nm, input w_t act_v, input w_t exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act_v, exp_v, cyc);
    end
  endtask

  // Monitor: samples on the falling edge and predicts what the next rising edge commits.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      adr_q.delete();
      out_n = 0; infl_b = 0; busy_m = 0; done_exp = 0; held = 0;
    end else begin
      pop = m_valid_o && m_ready_i;
      act = {m_data_o, m_last_o};
      nd  = 0;
      chk("done", w_t'(done_o), w_t'(done_exp));
      chk("busy", w_t'(busy_o), w_t'(busy_m));
      chk("we", w_t'(sram_we_o), 0);
      chk("valid_unexpected", w_t'(m_valid_o && exp_q.size() == 0), 0);
      if (held) begin
        chk("hold_valid", w_t'(m_valid_o), 1);
        chk("hold_stable", w_t'(act), w_t'(held_b));
      end
      if (pop && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("beat", w_t'(act), w_t'(b));
        beats++;
        beat_cyc.push_back(cyc);
        if (b.l) begin busy_m = 0; nd = 1; end
      end
      held = m_valid_o && !m_ready_i;
      held_b = act;
      chk("req_unexpected", w_t'(sram_req_o && adr_q.size() == 0), 0);
      if (sram_req_o && adr_q.size() > 0) chk("addr", w_t'(sram_addr_o), w_t'(adr_q.pop_front()));
      chk("req_while_full", w_t'((out_n - int'(infl_b) == 2) && !pop && sram_req_o), 0);
      out_n = out_n + int'(sram_req_o) - int'(pop);
      infl_b = sram_req_o;
      chk("occ_bound", w_t'(out_n > 2), 0);
      if (done_o) dones++;
      if (start_i && !busy_m && !done_exp) begin
        if (len_i == '0) nd = 1;
        else begin
          busy_m = 1;
          for (int k = 0; k < int'(len_i); k++) begin
            adr_q.push_back(base_addr_i + AW'(k));
            exp_q.push_back({mem[base_addr_i + AW'(k)], k == int'(len_i) - 1});
          end
        end
      end
      done_exp = nd;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      ph++;
      m_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? ((ph % 4 == 0) || (ph % 4 == 3)) : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic burst(input logic [AW-1:0] ba, input logic [LW-1:0] ln);
    @(posedge clk); #1;
    start_i = 1; base_addr_i = ba; len_i = ln; start_cyc = cyc;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic wait_idle(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if (!busy_m && !done_exp && exp_q.size() == 0) begin ok = 1; break; end
    end
    chk("idle_timeout", w_t'(ok), 1);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_valid"}, w_t'(m_valid_o), 0);
    chk({nm, "_data"}, w_t'(m_data_o), 0);
    chk({nm, "_last"}, w_t'(m_last_o), 0);
    chk({nm, "_busy"}, w_t'(busy_o), 0);
    chk({nm, "_done"}, w_t'(done_o), 0);
    chk({nm, "_req"}, w_t'(sram_req_o), 0);
    chk({nm, "_addr"}, w_t'(sram_addr_o), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
  endtask

  initial begin
    int b0, d0;
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1;
    // Basic burst: latency and back-to-back beats.
    rmode = 0;
    beat_cyc.delete();
    burst(10'h010, 4);
    wait_idle(50);
    chk("burst4_count", w_t'(beat_cyc.size()), 4);
    if (beat_cyc.size() == 4) begin
      chk("first_latency", w_t'(beat_cyc[0] - start_cyc), 3);
      chk("back_to_back", w_t'(beat_cyc[3] - beat_cyc[0]), 3);
    end
    // Address wrap.
    fill_random();
    burst(10'd1022, 4);
    wait_idle(50);
    // Back-pressure pattern 1,0,0,1.
    rmode = 1;
    b0 = beats;
    burst(10'($urandom), 8);
    wait_idle(200);
    chk("bp_beats", w_t'(beats - b0), 8);
    // Zero-length burst.
    rmode = 0;
    d0 = dones;
    burst(10'd5, 0);
    wait_idle(20);
    chk("len0_done", w_t'(dones - d0), 1);
    // Start while busy is ignored.
    rmode = 2;
    b0 = beats; d0 = dones;
    burst(10'd100, 16);
    repeat (3) @(posedge clk);
    burst(10'd200, 7);
    wait_idle(300);
    chk("busy_start_beats", w_t'(beats - b0), 16);
    chk("busy_start_dones", w_t'(dones - d0), 1);
    // Reset in the middle of a burst.
    rmode = 0;
    b0 = beats; d0 = dones;
    burst(10'd300, 10);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (beats >= b0 + 3) break;
    end
    #2 rst_n = 0;
    #1 check_zero("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("midreset_no_done", w_t'(dones - d0), 0);
    b0 = beats;
    burst(10'd50, 2);
    wait_idle(50);
    chk("post_reset_beats", w_t'(beats - b0), 2);
    // Random bursts, including a full-depth one.
    for (int t = 0; t < 8; t++) begin
      rmode = t % 3;
      fill_random();
      b0 = beats;
      burst(10'($urandom), t == 7 ? 11'd1024 : 11'($urandom_range(1, 40)));
      wait_idle(3000);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
